// File: rtl/clave_judge.sv
// Judges each strike of a 3-2 son clave bar pair against the tick counter.
// Tallies hits, misses and stray presses, and drives cue, pulse and done flags.
module clave_judge #(
    parameter logic [12:0] HIT0   = 13'd800,
    parameter logic [12:0] HIT1   = 13'd2000,
    parameter logic [12:0] HIT2   = 13'd3200,
    parameter logic [12:0] HIT3   = 13'd4800,
    parameter logic [12:0] HIT4   = 13'd5600,
    parameter logic [12:0] WINDOW = 13'd150
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [12:0] count,
    input  logic        key,
    output logic [2:0]  score,
    output logic [2:0]  misses,
    output logic [3:0]  strays,
    output logic [2:0]  slot,
    output logic        cue,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, ARMED, WIN, DONE} state_t;

    state_t      state;
    logic        key_q;
    logic        press;
    logic [12:0] tgt;
    logic [12:0] lo;
    logic [12:0] hi;

    assign press = key & ~key_q;
    assign cue   = (state == WIN);

    always_comb begin
        tgt = HIT4;
        case (slot)
            3'd0:    tgt = HIT0;
            3'd1:    tgt = HIT1;
            3'd2:    tgt = HIT2;
            3'd3:    tgt = HIT3;
            default: tgt = HIT4;
        endcase
        lo = tgt - WINDOW;
        hi = tgt + WINDOW;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            key_q      <= 1'b0;
            score      <= 3'd0;
            misses     <= 3'd0;
            strays     <= 4'd0;
            slot       <= 3'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            done       <= 1'b0;
        end else begin
            key_q      <= key;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            if (go) begin
                state  <= ARMED;
                score  <= 3'd0;
                misses <= 3'd0;
                strays <= 4'd0;
                slot   <= 3'd0;
                done   <= 1'b0;
            end else begin
                case (state)
                    // ARMED and WIN share judging so a press landing exactly on lo
                    // is scored before the cue has had a cycle to rise.
                    ARMED, WIN: begin
                        if (count < lo) begin
                            if (press && strays != 4'hF)
                                strays <= strays + 4'd1;
                        end else if ((press && count <= hi) || count > hi) begin
                            if (press && count <= hi) begin
                                hit_pulse <= 1'b1;
                                score     <= score + 3'd1;
                            end else begin
                                miss_pulse <= 1'b1;
                                misses     <= misses + 3'd1;
                            end
                            slot <= slot + 3'd1;
                            if (slot == 3'd4) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ARMED;
                            end
                        end else begin
                            state <= WIN;
                        end
                    end
                    DONE: begin
                        if (press && strays != 4'hF)
                            strays <= strays + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
